// File: rtl/aes_block_loader.sv
// Byte-serial to block-parallel loader for the AES128 datapath.
// Packs NBYTES bytes MSB-first into one block and holds it until the consumer takes it.
module aes_block_loader #(
    parameter int NBYTES = 16,
    parameter int CW     = $clog2(NBYTES)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clear,
    input  logic                  in_valid,
    input  logic [7:0]            in_data,
    output logic                  in_ready,
    output logic                  out_valid,
    output logic [8*NBYTES-1:0]   out_block,
    input  logic                  out_ready,
    output logic [CW-1:0]         byte_cnt,
    output logic                  busy
);

    typedef enum logic {
        FILL = 1'b0,
        HOLD = 1'b1
    } state_t;

    state_t              state_q, state_d;
    logic [CW-1:0]       byte_cnt_q, byte_cnt_d;
    logic [8*NBYTES-1:0] block_q, block_d;
    logic                out_valid_q, out_valid_d;
    logic                accept;

    // Gated by rst_n so nothing is offered while reset is held.
    assign in_ready  = rst_n && (state_q == FILL) && !clear;
    assign accept    = in_valid && in_ready;
    assign out_valid = out_valid_q;
    assign out_block = block_q;
    assign byte_cnt  = byte_cnt_q;
    assign busy      = (byte_cnt_q != '0) || out_valid_q;

    always_comb begin
        state_d     = state_q;
        byte_cnt_d  = byte_cnt_q;
        block_d     = block_q;
        out_valid_d = out_valid_q;
        case (state_q)
            FILL: begin
                if (clear) begin
                    byte_cnt_d = '0;
                end else if (accept) begin
                    block_d = {block_q[8*NBYTES-9:0], in_data};
                    if (byte_cnt_q == CW'(NBYTES - 1)) begin
                        byte_cnt_d  = '0;
                        state_d     = HOLD;
                        out_valid_d = 1'b1;
                    end else begin
                        byte_cnt_d = byte_cnt_q + CW'(1);
                    end
                end
            end
            HOLD: begin
                if (out_ready) begin
                    state_d     = FILL;
                    out_valid_d = 1'b0;
                end
            end
            default: begin
                state_d     = FILL;
                out_valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= FILL;
            byte_cnt_q  <= '0;
            block_q     <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            byte_cnt_q  <= byte_cnt_d;
            block_q     <= block_d;
            out_valid_q <= out_valid_d;
        end
    end

endmodule

// File: tb/tb_aes_block_loader.sv
// Self-checking bench for aes_block_loader: vector table, directed corner sequences,
// and randomized traffic against a queue-based reference model.
module tb_aes_block_loader;

    localparam int NB = 16;
    localparam int CW = $clog2(NB);
    localparam int BW = 8 * NB;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          clear = 1'b0;
    logic          in_valid = 1'b0;
    logic [7:0]    in_data = '0;
    logic          out_ready = 1'b0;
    logic          in_ready;
    logic          out_valid;
    logic [BW-1:0] out_block;
    logic [CW-1:0] byte_cnt;
    logic          busy;

    int total = 0;
    int bad   = 0;

    aes_block_loader #(.NBYTES(NB)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear     (clear),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_block (out_block),
        .out_ready (out_ready),
        .byte_cnt  (byte_cnt),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk1(input string nm, input logic act, input logic exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0b expected %0b", nm, act, exp);
        end
    endtask

    task automatic chkw(input string nm, input logic [BW-1:0] act, input logic [BW-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic chki(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Block whose byte k (in arrival order) is first+k.
    function automatic logic [BW-1:0] seq_block(input logic [7:0] first);
        logic [BW-1:0] b;
        b = '0;
        for (int k = 0; k < NB; k++) b[BW-1-8*k -: 8] = first + 8'(k);
        return b;
    endfunction

    task automatic send(input logic [7:0] first, input int n);
        for (int i = 0; i < n; i++) begin
            int w;
            in_valid = 1'b1;
            in_data  = first + 8'(i);
            w = 0;
            while (!in_ready && w < 40) begin
                tick();
                w++;
            end
            if (w == 40) chk1("send_timeout", in_ready, 1'b1);
            tick();
        end
        in_valid = 1'b0;
    endtask

    typedef struct {
        logic          clr;
        logic          iv;
        logic [7:0]    d;
        logic          ordy;
        logic          e_irdy;
        logic          e_ov;
        int            e_cnt;
        logic          chk_blk;
        logic [BW-1:0] e_blk;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic clr, input logic iv, input logic [7:0] d, input logic ordy,
                       input logic e_irdy, input logic e_ov, input int e_cnt,
                       input logic chk_blk, input logic [BW-1:0] e_blk);
        vec_t v;
        v.clr = clr; v.iv = iv; v.d = d; v.ordy = ordy;
        v.e_irdy = e_irdy; v.e_ov = e_ov; v.e_cnt = e_cnt;
        v.chk_blk = chk_blk; v.e_blk = e_blk;
        vecs.push_back(v);
    endtask

    initial begin
        logic [BW-1:0] blk10, blk0;
        int acc, first_acc, second_acc, ov_cycles, ov_first, errs, expcnt;
        logic [7:0] part[$];
        logic held;
        logic [BW-1:0] hblk;

        // Vector table: clear mid-fill, clear during HOLD, delivery.
        blk10 = seq_block(8'h10);
        for (int i = 0; i < 5; i++) add(0, 1, 8'h50 + 8'(i), 0, 1, 0, i, 0, '0);
        add(1, 1, 8'hAA, 0, 0, 0, 5, 0, '0);
        for (int i = 0; i < NB; i++) add(0, 1, 8'h10 + 8'(i), 0, 1, 0, i, 0, '0);
        add(0, 1, 8'hEE, 0, 0, 1, 0, 1, blk10);
        add(1, 1, 8'hEE, 0, 0, 1, 0, 1, blk10);
        add(1, 0, 8'h00, 1, 0, 1, 0, 1, blk10);
        add(0, 0, 8'h00, 0, 1, 0, 0, 0, '0);

        // Reset state
        #12;
        chk1("rst_in_ready", in_ready, 1'b0);
        chk1("rst_out_valid", out_valid, 1'b0);
        chki("rst_byte_cnt", int'(byte_cnt), 0);
        chk1("rst_busy", busy, 1'b0);
        chkw("rst_block", out_block, '0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        #1;
        chk1("post_rst_in_ready", in_ready, 1'b1);

        foreach (vecs[i]) begin
            clear = vecs[i].clr; in_valid = vecs[i].iv;
            in_data = vecs[i].d; out_ready = vecs[i].ordy;
            #1;
            chk1("vec_in_ready", in_ready, vecs[i].e_irdy);
            chk1("vec_out_valid", out_valid, vecs[i].e_ov);
            chki("vec_byte_cnt", int'(byte_cnt), vecs[i].e_cnt);
            chk1("vec_busy", busy, (vecs[i].e_cnt != 0) || vecs[i].e_ov);
            if (vecs[i].chk_blk) chkw("vec_block", out_block, vecs[i].e_blk);
            tick();
        end
        clear = 0; in_valid = 0; out_ready = 0;

        // Back-to-back, out_ready held high
        acc = 0; first_acc = -1; second_acc = -1; ov_cycles = 0; ov_first = -1;
        in_valid = 1; out_ready = 1;
        for (int cyc = 0; cyc < 34; cyc++) begin
            in_data = 8'(acc);
            #1;
            if (out_valid) begin
                ov_cycles++;
                if (ov_cycles == 1) begin
                    ov_first = cyc;
                    chkw("b2b_block0", out_block, seq_block(8'h00));
                end else if (ov_cycles == 2) begin
                    chkw("b2b_block1", out_block, seq_block(8'h10));
                end
            end
            if (in_ready) begin
                if (acc == 0) first_acc = cyc;
                if (acc == NB) second_acc = cyc;
                acc++;
            end
            tick();
        end
        in_valid = 0; out_ready = 0;
        chki("b2b_ov_latency", ov_first, 16);
        chki("b2b_ov_cycles", ov_cycles, 2);
        chki("b2b_block_period", second_acc - first_acc, 17);
        chki("b2b_accepts", acc, 2 * NB);

        // Backpressure
        send(8'h30, NB);
        in_valid = 1; in_data = 8'hCC;
        blk0 = out_block;
        chkw("bp_block", blk0, seq_block(8'h30));
        errs = 0;
        for (int c = 0; c < 10; c++) begin
            #1;
            if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_block !== blk0) errs++;
            tick();
        end
        chki("bp_stall_violations", errs, 0);
        out_ready = 1;
        #1;
        chk1("bp_take_in_ready", in_ready, 1'b0);
        in_valid = 0;
        tick();
        out_ready = 0;
        chk1("bp_after_in_ready", in_ready, 1'b1);
        chk1("bp_after_out_valid", out_valid, 1'b0);

        // Gapped input
        acc = 0; expcnt = 0; errs = 0;
        for (int cyc = 0; cyc < 40 && acc < NB; cyc++) begin
            in_valid = (cyc % 2) == 0;
            in_data = 8'(acc);
            #1;
            if (int'(byte_cnt) != expcnt) errs++;
            if (in_valid && in_ready) begin
                acc++;
                expcnt = acc % NB;
            end
            tick();
        end
        in_valid = 0;
        chki("gap_accepts", acc, NB);
        chki("gap_cnt_violations", errs, 0);
        chk1("gap_out_valid", out_valid, 1'b1);
        chkw("gap_block", out_block, seq_block(8'h00));
        out_ready = 1; tick(); out_ready = 0;

        // Asynchronous reset mid-fill
        send(8'h40, 9);
        chki("arst_fill_cnt", int'(byte_cnt), 9);
        #3 rst_n = 0;
        #1;
        chk1("arst_fill_ov", out_valid, 1'b0);
        chki("arst_fill_cnt0", int'(byte_cnt), 0);
        chk1("arst_fill_busy", busy, 1'b0);
        chk1("arst_fill_in_ready", in_ready, 1'b0);
        #2 rst_n = 1;
        tick();
        send(8'h60, NB);
        chk1("arst_refill_ov", out_valid, 1'b1);
        chkw("arst_refill_block", out_block, seq_block(8'h60));

        // Asynchronous reset during HOLD
        #3 rst_n = 0;
        #1;
        chk1("arst_hold_ov", out_valid, 1'b0);
        chk1("arst_hold_busy", busy, 1'b0);
        chkw("arst_hold_block", out_block, '0);
        #2 rst_n = 1;
        tick();
        send(8'h70, NB);
        chkw("arst_hold_refill_block", out_block, seq_block(8'h70));
        out_ready = 1; tick(); out_ready = 0;

        // Randomized traffic against a queue model
        part.delete();
        held = 1'b0;
        hblk = '0;
        for (int cyc = 0; cyc < 2000; cyc++) begin
            clear     = ($urandom_range(15) == 0);
            in_valid  = ($urandom_range(3) != 0);
            in_data   = 8'($urandom);
            out_ready = ($urandom_range(1) == 1);
            #1;
            chk1("rnd_in_ready", in_ready, !held && !clear);
            chk1("rnd_out_valid", out_valid, held);
            chki("rnd_byte_cnt", int'(byte_cnt), part.size());
            chk1("rnd_busy", busy, held || (part.size() != 0));
            if (held) chkw("rnd_block", out_block, hblk);
            if (held) begin
                if (out_ready) held = 1'b0;
            end else if (clear) begin
                part.delete();
            end else if (in_valid) begin
                part.push_back(in_data);
                if (part.size() == NB) begin
                    for (int k = 0; k < NB; k++) hblk[BW-1-8*k -: 8] = part[k];
                    held = 1'b1;
                    part.delete();
                end
            end
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
